// File: rtl/fetch_if.sv
// ============================================================================
// fetch_if : fetch-stage bus (instruction memory side and decode side)
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch;
   logic        zero;
   logic [31:0] branch_offset;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired;

   modport master (
      output imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, retired,
      input  imem_ack, imem_rdata, instr_ready, branch, zero, branch_offset
   );

   modport slave (
      input  imem_req, imem_addr, instr, opcode, instr_valid, pc, pc_plus4, retired,
      output imem_ack, imem_rdata, instr_ready, branch, zero, branch_offset
   );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC register, imem req/ack fetch and branch next-PC selection
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst,
   fetch_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;
   logic        imem_req_q;
   logic        instr_valid_q;

   logic [31:0] pc_plus4_w;
   logic [31:0] pc_d;
   logic [31:0] retired_d;

   assign pc_plus4_w = pc_q + 32'd4;
   // Offset is in words; the two bits shifted out of the top are dropped.
   assign pc_d       = (bus.branch & bus.zero) ? (pc_plus4_w + {bus.branch_offset[29:0], 2'b00})
                                               : pc_plus4_w;
   assign retired_d  = retired_q + 32'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         retired_q     <= 32'h0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q    <= FETCH;
               imem_req_q <= 1'b1;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  instr_q       <= bus.imem_rdata;
                  state_q       <= HOLD;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  pc_q          <= pc_d;
                  retired_q     <= retired_d;
                  state_q       <= FETCH;
                  imem_req_q    <= 1'b1;
                  instr_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.opcode      = instr_q[31:26];
   assign bus.instr_valid = instr_valid_q;
   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4_w;
   assign bus.retired     = retired_q;

endmodule

`default_nettype wire
